// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//
// Receive side of the UART. The asynchronous serial line is brought into the
// clock domain through a two-flop synchronizer. The line is then oversampled
// by a bit-period counter. A start bit is confirmed at its middle. Eight data
// bits are shifted in LSB-first, and the stop bit is checked. A good frame
// updates data_out together with a one-cycle valid pulse. A low stop bit
// raises a one-cycle frame_err pulse instead, and the receiver then parks
// until the line returns high.
//
// Output handshake: valid is a strobe with no back-pressure. The consumer
// must capture data_out in the cycle valid is high. data_out then holds that
// byte until the next good frame. valid and frame_err are never high in the
// same cycle.
//
// Parameters
//   divisor    clock cycles per bit period (4 .. 65536)
//
// Ports
//   clk        system clock, rising edge
//   RSTn       asynchronous active-low reset
//   RX         serial input, asynchronous to clk, idle high
//   data_out   last correctly framed byte
//   valid      one-cycle pulse, data_out updated this cycle
//   frame_err  one-cycle pulse, stop bit sampled low (byte discarded)
//   busy       high whenever the receiver is not idle
//   dbg_state  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int unsigned divisor = 10
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  // Terminal counts of the bit-period counter. The start bit is checked
  // half a period in. Every later bit is checked one full period after the
  // previous sample, so all samples land mid-bit.
  localparam logic [15:0] HalfM1 = 16'((divisor >> 1) - 1);
  localparam logic [15:0] DivM1  = 16'(divisor - 1);

  // Synchronizer. Both stages reset high so that the line looks idle
  // straight out of reset.
  logic sync1_q;
  logic sync2_q;
  logic rx_s;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // State and datapath registers
  state_e      state_q,    state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q,  bit_cnt_d;
  logic [7:0]  shift_q,    shift_d;
  logic [7:0]  data_q,     data_d;
  logic        valid_q,    valid_d;
  logic        ferr_q,     ferr_d;

  logic start_sample;
  logic bit_sample;

  assign start_sample = (baud_cnt_q == HalfM1);
  assign bit_sample   = (baud_cnt_q == DivM1);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic. baud_cnt returns to zero whenever a state is (re)entered.
  // It only runs while a bit is being timed.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_cnt_d = 16'd0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (start_sample) begin
          baud_cnt_d = 16'd0;
          if (rx_s) begin
            // Line went high again before mid start bit: treat it as a glitch.
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      S_DATA: begin
        if (bit_sample) begin
          baud_cnt_d                = 16'd0;
          shift_d[bit_cnt_q[2:0]]   = rx_s;
          bit_cnt_d                 = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      S_STOP: begin
        if (bit_sample) begin
          baud_cnt_d = 16'd0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      S_BREAK: begin
        // A line held low would otherwise look like a new start bit.
        // Wait for the line to go high before re-arming.
        baud_cnt_d = 16'd0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = 16'd0;
        bit_cnt_d  = 4'd0;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
//
// Two receivers share the clock and the reset: one has divisor 10 and one
// has divisor 7. Serial frames are driven bit by bit. For each frame, the
// expected outcome is pushed into that receiver's queue: the pulse kind, the
// byte, and the cycle of the pulse. The cycle comes from the frame timing
// rule E0 + 2 + half + 9*divisor. One monitor per receiver pops the queue
// whenever the receiver raises valid or frame_err. Each monitor also checks
// on every cycle that data_out holds the last good byte.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

  // Clock / reset
  logic clk = 1'b0;
  logic RSTn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic       rx10 = 1'b1, rx7 = 1'b1;
  logic [7:0] dout10, dout7;
  logic       valid10, valid7, ferr10, ferr7, busy10, busy7;
  logic [2:0] st10, st7;

  uart_rx_fsm #(.divisor(10)) u_dut10 (
    .clk(clk), .RSTn(RSTn), .RX(rx10), .data_out(dout10), .valid(valid10),
    .frame_err(ferr10), .busy(busy10), .dbg_state(st10)
  );

  uart_rx_fsm #(.divisor(7)) u_dut7 (
    .clk(clk), .RSTn(RSTn), .RX(rx7), .data_out(dout7), .valid(valid7),
    .frame_err(ferr7), .busy(busy7), .dbg_state(st7)
  );

  // Scoreboard: {is_frame_err, byte, pulse_cycle}
  logic [40:0] exp10_q[$];
  logic [40:0] exp7_q[$];
  logic [7:0]  last10 = 8'h00, last7 = 8'h00;
  logic [40:0] e10, e7;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Driver tasks (called at a falling edge)
  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx7 = v;
    else     rx10 = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic stop_bit);
    int div;
    int e0;
    int expc;
    logic [9:0] bits;
    div  = sel ? 7 : 10;
    bits = {stop_bit, b, 1'b0};
    e0   = cyc + 1;  // first rising edge that registers the start bit
    expc = e0 + 2 + (div / 2) + 9 * div;
    if (sel) exp7_q.push_back({~stop_bit, b, 32'(expc)});
    else     exp10_q.push_back({~stop_bit, b, 32'(expc)});
    for (int i = 0; i < 10; i++) begin
      set_rx(sel, bits[i]);
      repeat (div) @(negedge clk);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (RSTn) begin
      if (exp10_q.size() != 0 && cyc > int'(exp10_q[0][31:0])) begin
        check("pulse_missing_d10", 64'(cyc), 64'(exp10_q[0][31:0]));
        void'(exp10_q.pop_front());
      end
      if (valid10 || ferr10) begin
        check("dual_pulse_d10", 64'(valid10 & ferr10), 64'd0);
        check("pulse_expected_d10", 64'(exp10_q.size() != 0), 64'd1);
        if (exp10_q.size() != 0) begin
          e10 = exp10_q.pop_front();
          check("pulse_kind_d10", 64'(ferr10), 64'(e10[40]));
          check("pulse_cycle_d10", 64'(cyc), 64'(e10[31:0]));
          if (!e10[40]) last10 = e10[39:32];
        end
      end
      check("data_out_d10", 64'(dout10), 64'(last10));
    end
  end

  always @(negedge clk) begin
    if (RSTn) begin
      if (exp7_q.size() != 0 && cyc > int'(exp7_q[0][31:0])) begin
        check("pulse_missing_d7", 64'(cyc), 64'(exp7_q[0][31:0]));
        void'(exp7_q.pop_front());
      end
      if (valid7 || ferr7) begin
        check("dual_pulse_d7", 64'(valid7 & ferr7), 64'd0);
        check("pulse_expected_d7", 64'(exp7_q.size() != 0), 64'd1);
        if (exp7_q.size() != 0) begin
          e7 = exp7_q.pop_front();
          check("pulse_kind_d7", 64'(ferr7), 64'(e7[40]));
          check("pulse_cycle_d7", 64'(cyc), 64'(e7[31:0]));
          if (!e7[40]) last7 = e7[39:32];
        end
      end
      check("data_out_d7", 64'(dout7), 64'(last7));
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    chk_cnt++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Stimulus
  initial begin
    int busy_cnt;
    int gap;
    logic [7:0] b;
    logic sb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", 64'(dout10), 64'h00);
    check("rst_valid", 64'(valid10), 64'd0);
    check("rst_frame_err", 64'(ferr10), 64'd0);
    check("rst_busy", 64'(busy10), 64'd0);
    check("rst_state", 64'(st10), 64'd0);
    check("rst_busy_d7", 64'(busy7), 64'd0);
    @(negedge clk) RSTn = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte 0x55: busy mid-frame, pulse and idle at E97
    fork
      send(1'b0, 8'h55, 1'b1);
      begin
        repeat (50) @(negedge clk);
        check("single_busy_mid", 64'(busy10), 64'd1);
        repeat (48) @(negedge clk);
        check("single_valid_e97", 64'(valid10), 64'd1);
        check("single_data", 64'(dout10), 64'h55);
        check("single_busy_drop", 64'(busy10), 64'd0);
      end
    join
    repeat (3) @(negedge clk);

    // Back-to-back frames with no idle gap
    send(1'b0, 8'hA5, 1'b1);
    send(1'b0, 8'h3C, 1'b1);
    repeat (5) @(negedge clk);

    // Glitch: 3-cycle low pulse must abort in START
    rx10 = 1'b0;
    repeat (3) @(negedge clk);
    rx10 = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy10) busy_cnt++;
    end
    check("glitch_busy_seen", 64'(busy_cnt > 0), 64'd1);
    check("glitch_busy_clear", 64'(busy10), 64'd0);

    // Framing error then held-low line (BREAK)
    send(1'b0, 8'hFF, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy10) busy_cnt++;
    end
    check("break_busy_held", 64'(busy_cnt), 64'd50);
    rx10 = 1'b1;
    repeat (5) @(negedge clk);
    check("break_released", 64'(busy10), 64'd0);

    // Reset during data bit 4 of 0x81 (bits LSB-first: 1,0,0,0,0,...)
    rx10 = 1'b0;                               // start bit
    repeat (10) @(negedge clk);
    rx10 = 1'b1;                               // bit 0
    repeat (10) @(negedge clk);
    rx10 = 1'b0;                               // bits 1..3
    repeat (30) @(negedge clk);
    repeat (5) @(negedge clk);                 // halfway into bit 4
    #2 RSTn = 1'b0;
    #1;
    check("async_rst_data", 64'(dout10), 64'h00);
    check("async_rst_busy", 64'(busy10), 64'd0);
    check("async_rst_valid", 64'(valid10), 64'd0);
    check("async_rst_state", 64'(st10), 64'd0);
    last10 = 8'h00;
    last7  = 8'h00;
    repeat (3) @(negedge clk);
    rx10 = 1'b1;
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_idle", 64'(busy10), 64'd0);
    send(1'b0, 8'h81, 1'b1);
    repeat (3) @(negedge clk);

    // Odd divisor: 0x96 at divisor 7 (pulse at E68)
    send(1'b1, 8'h96, 1'b1);
    repeat (3) @(negedge clk);

    // Randomized frames on both receivers
    for (int n = 0; n < 25; n++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 4) != 0);
      send(1'b0, b, sb);
      rx10 = 1'b1;
      gap = sb ? $urandom_range(0, 12) : $urandom_range(4, 12);
      repeat (gap) @(negedge clk);
    end
    for (int n = 0; n < 25; n++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 4) != 0);
      send(1'b1, b, sb);
      rx7 = 1'b1;
      gap = sb ? $urandom_range(0, 12) : $urandom_range(4, 12);
      repeat (gap) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("queue_empty_d10", 64'(exp10_q.size()), 64'd0);
    check("queue_empty_d7", 64'(exp7_q.size()), 64'd0);
    check("final_idle_d10", 64'(busy10), 64'd0);
    check("final_idle_d7", 64'(busy7), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
